// File: rtl/conv_bin_bcd_display_pkg.sv
// Shared types and constants for the binary-to-BCD result/display stage.
package conv_bin_bcd_display_pkg;

  localparam int unsigned VAL_W = 9;
  localparam int unsigned BCD_W = 12;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int unsigned i = 0; i < BCD_W / 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_bin_bcd_display_if.sv
// Capture request/operand inputs and result/display outputs of conv_bin_bcd_display.
interface conv_bin_bcd_display_if;
  import conv_bin_bcd_display_pkg::*;

  logic             start;
  logic [7:0]       S;
  logic             Carry;
  logic             Ovf;
  logic             busy;
  logic             done;
  logic [BCD_W-1:0] bcd;
  logic             neg;
  logic             ovf_led;
  logic [3:0]       an;
  logic [6:0]       seg;

  modport master (
    output start, S, Carry, Ovf,
    input  busy, done, bcd, neg, ovf_led, an, seg
  );

  modport slave (
    input  start, S, Carry, Ovf,
    output busy, done, bcd, neg, ovf_led, an, seg
  );
endinterface

// File: rtl/conv_bin_bcd_display_dec7seg.sv
// Combinational BCD digit to active-low {g,f,e,d,c,b,a} segment decoder.
module dec7seg
  import conv_bin_bcd_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0: seg_o = 7'b1000000;
      4'd1: seg_o = 7'b1111001;
      4'd2: seg_o = 7'b0100100;
      4'd3: seg_o = 7'b0110000;
      4'd4: seg_o = 7'b0011001;
      4'd5: seg_o = 7'b0010010;
      4'd6: seg_o = 7'b0000010;
      4'd7: seg_o = 7'b1111000;
      4'd8: seg_o = 7'b0000000;
      4'd9: seg_o = 7'b0010000;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/conv_bin_bcd_display.sv
// Adder result stage: captures {Carry,S}, converts to 3 BCD digits, scans a 4-digit display.
// Optional SIGNED_MODE_EN: treat S as two's complement and show '-' on digit 3.
module conv_bin_bcd_display
  import conv_bin_bcd_display_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned REFRESH_HZ = 1000
) (
  input logic                  clk,
  input logic                  rst,
  conv_bin_bcd_display_if.slave bus
);

  localparam int unsigned SCAN_DIV_RAW = CLK_HZ / (4 * REFRESH_HZ);
  localparam int unsigned SCAN_DIV     = (SCAN_DIV_RAW == 0) ? 1 : SCAN_DIV_RAW;
  localparam int unsigned SCAN_W       = ($clog2(SCAN_DIV) < 1) ? 1 : $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [3:0]        LAST_ITER = 4'(VAL_W - 1);

  state_t             state_q, state_d;
  logic [3:0]         iter_q, iter_d;
  logic [VAL_W-1:0]   val_q, val_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W+VAL_W-1:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      val_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      val_q   <= val_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    val_d   = val_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    adj     = bcd_adjust(scr_q);
    sh      = {adj[BCD_W-2:0], val_q, 1'b0};
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
`ifdef SIGNED_MODE_EN
          neg_d = bus.S[7];
          val_d = bus.S[7] ? {1'b0, 8'(~bus.S + 8'd1)} : {1'b0, bus.S};
`else
          val_d = {bus.Carry, bus.S};
`endif
          ovf_d   = bus.Ovf;
          scr_d   = '0;
          iter_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scr_d  = sh[BCD_W+VAL_W-1:VAL_W];
        val_d  = sh[VAL_W-1:0];
        iter_d = iter_q + 4'd1;
        // Load the held result on the final shift so bcd is valid alongside done.
        if (iter_q == LAST_ITER) begin
          bcd_d   = sh[BCD_W+VAL_W-1:VAL_W];
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy    = (state_q == ST_SHIFT);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.bcd     = bcd_q;
  assign bus.ovf_led = ovf_q;
`ifdef SIGNED_MODE_EN
  assign bus.neg     = neg_q;
`else
  assign bus.neg     = 1'b0;
`endif

  logic [SCAN_W-1:0] scan_cnt_q;
  logic [1:0]        digit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      digit_q    <= '0;
    end else if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_q <= '0;
      digit_q    <= digit_q + 2'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  logic [3:0] nib;
  logic       force_seg;
  logic [6:0] forced;
  logic [6:0] dec_seg;

  always_comb begin
    nib       = '0;
    force_seg = 1'b0;
    forced    = SEG_BLANK;
    case (digit_q)
      2'd0: nib = bcd_q[3:0];
      2'd1: begin
        nib       = bcd_q[7:4];
        force_seg = (bcd_q[11:4] == 8'd0);
      end
      2'd2: begin
        nib       = bcd_q[11:8];
        force_seg = (bcd_q[11:8] == 4'd0);
      end
      default: begin
        force_seg = 1'b1;
        forced    = bus.neg ? SEG_MINUS : SEG_BLANK;
      end
    endcase
  end

  dec7seg u_dec7seg (
    .bcd_i (nib),
    .seg_o (dec_seg)
  );

  assign bus.an  = ~(4'b0001 << digit_q);
  assign bus.seg = force_seg ? forced : dec_seg;

endmodule

// File: tb/tb_conv_bin_bcd_display.sv
// Self-checking bench for conv_bin_bcd_display with an arithmetic reference model.
module tb_conv_bin_bcd_display;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_bin_bcd_display_if bus ();

  conv_bin_bcd_display #(
    .CLK_HZ     (16),
    .REFRESH_HZ (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int scan_k;
  int exp_val;
  logic exp_neg;

  logic [6:0] seg_tbl [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

  // Rising edges since reset release: 4 cycles per digit with SCAN_DIV=4.
  always @(posedge clk or posedge rst)
    if (rst) scan_k <= 0;
    else     scan_k <= scan_k + 1;

  function automatic int model_value(input logic [7:0] s, input logic c);
`ifdef SIGNED_MODE_EN
    return s[7] ? 256 - int'(s) : int'(s);
`else
    return int'(c) * 256 + int'(s);
`endif
  endfunction

  function automatic logic model_neg(input logic [7:0] s);
`ifdef SIGNED_MODE_EN
    return s[7];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [11:0] model_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic do_conv(input logic [7:0] s, input logic c, input logic o,
                         output int done_at, output int busy_cycles,
                         output int done_pulses, output logic [11:0] bcd_at_done);
    @(negedge clk);
    bus.start = 1'b1; bus.S = s; bus.Carry = c; bus.Ovf = o;
    done_at = -1; busy_cycles = 0; done_pulses = 0; bcd_at_done = 'x;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.done === 1'b1) begin
        done_pulses++;
        if (done_at < 0) begin done_at = n; bcd_at_done = bus.bcd; end
      end
      if (n == 1) bus.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.S = '0; bus.Carry = 1'b0; bus.Ovf = 1'b0;
    #3;
    tests_run++;
    if (bus.bcd !== 12'h000) begin tests_failed++; $display("FAIL reset_bcd: got %h expected 000", bus.bcd); end
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy_done: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    tests_run++;
    if (bus.neg !== 1'b0 || bus.ovf_led !== 1'b0) begin
      tests_failed++; $display("FAIL reset_neg_ovf: got neg=%b ovf_led=%b expected 0 0", bus.neg, bus.ovf_led);
    end
    tests_run++;
    if (bus.an !== 4'b1110) begin tests_failed++; $display("FAIL reset_an: got %b expected 1110", bus.an); end
    @(negedge clk);
    rst = 1'b0; exp_val = 0; exp_neg = 1'b0;
  endtask

  task automatic test_display();
    int idx, h, t, u;
    logic [6:0] es;
    logic [3:0] ea;
    h = exp_val / 100; t = (exp_val / 10) % 10; u = exp_val % 10;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      idx = (scan_k / 4) % 4;
      ea  = ~(4'b0001 << idx);
      case (idx)
        0:       es = seg_tbl[u];
        1:       es = (h == 0 && t == 0) ? 7'b1111111 : seg_tbl[t];
        2:       es = (h == 0) ? 7'b1111111 : seg_tbl[h];
        default: es = exp_neg ? 7'b0111111 : 7'b1111111;
      endcase
      tests_run++;
      if (bus.an !== ea) begin tests_failed++; $display("FAIL scan_an: value %0d got %b expected %b", exp_val, bus.an, ea); end
      tests_run++;
      if (bus.seg !== es) begin
        tests_failed++; $display("FAIL scan_seg: value %0d digit %0d got %b expected %b", exp_val, idx, bus.seg, es);
      end
    end
  endtask

  task automatic check_conv(input string name, input logic [7:0] s, input logic c, input logic o);
    int da, bc, dp, v;
    logic [11:0] bd;
    v = model_value(s, c);
    do_conv(s, c, o, da, bc, dp, bd);
    tests_run++;
    if (da !== 10 || dp !== 1) begin
      tests_failed++; $display("FAIL %s_latency: got done at %0d (%0d pulses) expected 10 (1)", name, da, dp);
    end
    tests_run++;
    if (bc !== 9) begin tests_failed++; $display("FAIL %s_busy: got %0d busy cycles expected 9", name, bc); end
    tests_run++;
    if (bd !== model_bcd(v) || bus.bcd !== model_bcd(v)) begin
      tests_failed++; $display("FAIL %s_bcd: got %h/%h expected %h", name, bd, bus.bcd, model_bcd(v));
    end
    tests_run++;
    if (bus.ovf_led !== o || bus.neg !== model_neg(s)) begin
      tests_failed++;
      $display("FAIL %s_flags: got ovf_led=%b neg=%b expected %b %b", name, bus.ovf_led, bus.neg, o, model_neg(s));
    end
    exp_val = v; exp_neg = model_neg(s);
  endtask

  task automatic test_directed();
    check_conv("s15", 8'd15, 1'b0, 1'b0);
    test_display();
    check_conv("s44c", 8'd44, 1'b1, 1'b0);
    check_conv("s0c", 8'd0, 1'b1, 1'b1);
    check_conv("s255c", 8'd255, 1'b1, 1'b0);
    test_display();
    check_conv("zero", 8'd0, 1'b0, 1'b0);
    test_display();
`ifdef SIGNED_MODE_EN
    check_conv("sAA", 8'hAA, 1'b0, 1'b1);
    tests_run++;
    if (bus.bcd !== 12'h086 || bus.neg !== 1'b1) begin
      tests_failed++; $display("FAIL signed_aa: got %h neg=%b expected 086 1", bus.bcd, bus.neg);
    end
    test_display();
    check_conv("s80", 8'h80, 1'b1, 1'b0);
    tests_run++;
    if (bus.bcd !== 12'h128) begin tests_failed++; $display("FAIL signed_80: got %h expected 128", bus.bcd); end
`else
    check_conv("uAA", 8'hAA, 1'b1, 1'b1);
    tests_run++;
    if (bus.bcd !== 12'h426 || bus.neg !== 1'b0) begin
      tests_failed++; $display("FAIL unsigned_aa: got %h neg=%b expected 426 0", bus.bcd, bus.neg);
    end
    test_display();
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      check_conv("rand", 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    test_display();
  endtask

  task automatic test_ignore_busy();
    int bc, dp, da;
    logic [7:0] a, b;
    a = 8'd123; b = 8'd77;
    @(negedge clk);
    bus.start = 1'b1; bus.S = a; bus.Carry = 1'b1; bus.Ovf = 1'b0;
    bc = 0; dp = 0; da = -1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) bc++;
      if (bus.done === 1'b1) begin dp++; if (da < 0) da = n; end
      bus.start = (n == 3 || n == 6 || n == 10) ? 1'b1 : 1'b0;
      bus.S = b; bus.Carry = 1'b0;
    end
    tests_run++;
    if (bc !== 9 || dp !== 1 || da !== 10) begin
      tests_failed++; $display("FAIL ignore_busy: got busy=%0d done=%0d at %0d expected 9 1 10", bc, dp, da);
    end
    tests_run++;
    if (bus.bcd !== model_bcd(model_value(a, 1'b1))) begin
      tests_failed++; $display("FAIL ignore_bcd: got %h expected %h", bus.bcd, model_bcd(model_value(a, 1'b1)));
    end
    exp_val = model_value(a, 1'b1); exp_neg = model_neg(a);
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [11:0] b1, b2;
    logic [7:0] a, b;
    a = 8'd42; b = 8'd201;
    @(negedge clk);
    bus.start = 1'b1; bus.S = a; bus.Carry = 1'b0; bus.Ovf = 1'b0;
    d1 = -1; d2 = -1; b1 = 'x; b2 = 'x;
    for (int n = 1; n <= 26; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (d1 < 0) begin d1 = n; b1 = bus.bcd; end
        else if (d2 < 0) begin d2 = n; b2 = bus.bcd; end
      end
      bus.S = b;
      if (n == 12) bus.start = 1'b0;
    end
    tests_run++;
    if (d1 !== 10 || d2 !== 21) begin
      tests_failed++; $display("FAIL b2b_timing: got done at %0d,%0d expected 10,21", d1, d2);
    end
    tests_run++;
    if (b1 !== model_bcd(model_value(a, 1'b0)) || b2 !== model_bcd(model_value(b, 1'b0))) begin
      tests_failed++; $display("FAIL b2b_bcd: got %h,%h expected %h,%h", b1, b2,
                               model_bcd(model_value(a, 1'b0)), model_bcd(model_value(b, 1'b0)));
    end
    exp_val = model_value(b, 1'b0); exp_neg = model_neg(b);
    test_display();
  endtask

  task automatic test_abort();
    int bc;
    @(negedge clk);
    bus.start = 1'b1; bus.S = 8'd99; bus.Carry = 1'b1; bus.Ovf = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    tests_run++;
    if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL abort_pre_busy: got %b expected 1", bus.busy); end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd !== 12'h000) begin
      tests_failed++; $display("FAIL abort_state: got busy=%b done=%b bcd=%h expected 0 0 000", bus.busy, bus.done, bus.bcd);
    end
    tests_run++;
    if (bus.ovf_led !== 1'b0 || bus.neg !== 1'b0 || bus.an !== 4'b1110) begin
      tests_failed++; $display("FAIL abort_outputs: got ovf_led=%b neg=%b an=%b expected 0 0 1110", bus.ovf_led, bus.neg, bus.an);
    end
    @(negedge clk);
    rst = 1'b0; exp_val = 0; exp_neg = 1'b0;
    bc = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) bc++;
    end
    tests_run++;
    if (bc !== 0 || bus.bcd !== 12'h000) begin
      tests_failed++; $display("FAIL abort_resume: got %0d active cycles bcd=%h expected 0 000", bc, bus.bcd);
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_directed();
    test_random();
    test_ignore_busy();
    test_back_to_back();
    test_abort();
    test_display();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
